// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter: FSM states,
// Booth step op codes and the default operand and product widths.
package booth_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;
  localparam int IDW_DEF  = 2;
  localparam int PW_DEF   = 2 * W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // {Q[0], q_1}: 10 starts a run of ones (subtract), 01 ends one (add).
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b10:   return OP_SUB;
      2'b01:   return OP_ADD;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Request/response bundle between client blocks and the shared multiplier.
// The master modport is the client side, the slave modport is the arbiter.
interface booth_mul_arbiter_if
  import booth_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*W-1:0]    rsp_p;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_id, busy
  );

endinterface

// File: rtl/booth_step_dp.sv
// One combinational radix-2 Booth step: optional add/sub of A into acc,
// then an arithmetic right shift of {acc, Q, q_1}.
module booth_step_dp
  import booth_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0]   acc,
  input  logic [W-1:0] q,
  input  logic         q_1,
  input  logic [W:0]   a,
  output logic [W:0]   acc_nxt,
  output logic [W-1:0] q_nxt,
  output logic         q_1_nxt
);

  booth_op_t  op;
  logic [W:0] sum;

  always_comb begin
    op = booth_decode(q[0], q_1);
    case (op)
      OP_ADD:  sum = acc + a;
      OP_SUB:  sum = acc - a;
      default: sum = acc;
    endcase
    acc_nxt = {sum[W], sum[W:1]};
    q_nxt   = {sum[0], q[W-1:1]};
    q_1_nxt = q[0];
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter in front of one sequential Booth multiplier; returns
// each signed product tagged with the index of the requester that owns it.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF
) (
  input logic clk,
  input logic rst,
  booth_mul_arbiter_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, win, id;
  logic           found, accept, last_step;
  logic [NREQ-1:0] req_ready;
  logic           busy;

  logic [W:0]     a_reg, acc, acc_nxt;
  logic [W-1:0]   q_reg, q_nxt, a_sel, b_sel;
  logic           q_1, q_1_nxt;
  logic [CW-1:0]  count;

  logic           rsp_valid;
  logic [2*W-1:0] rsp_p;
  logic [IDW-1:0] rsp_id;

  // First asserted request at or after ptr; the index wraps by width.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[ptr + IDW'(k)]) begin
        found = 1'b1;
        win   = ptr + IDW'(k);
      end
    end
  end

  assign a_sel     = bus.req_a[win*W +: W];
  assign b_sel     = bus.req_b[win*W +: W];
  assign accept    = (state == IDLE) && found;
  assign last_step = (state == CALC) && (count == CW'(1));

  booth_step_dp #(.W(W)) u_step (
    .acc     (acc),
    .q       (q_reg),
    .q_1     (q_1),
    .a       (a_reg),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q_1_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is gated by rst so nothing looks accepted while reset is held.
  always_comb begin
    req_ready = '0;
    if (accept && !rst) req_ready[win] = 1'b1;
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      id        <= '0;
      a_reg     <= '0;
      q_reg     <= '0;
      q_1       <= 1'b0;
      acc       <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_reg <= {a_sel[W-1], a_sel};
          q_reg <= b_sel;
          q_1   <= 1'b0;
          acc   <= '0;
          count <= CW'(W);
          id    <= win;
          ptr   <= win + IDW'(1);
        end
        CALC: begin
          acc   <= acc_nxt;
          q_reg <= q_nxt;
          q_1   <= q_1_nxt;
          count <= count - CW'(1);
          if (last_step) begin
            rsp_p     <= {acc_nxt[W-1:0], q_nxt};
            rsp_id    <= id;
            rsp_valid <= 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.busy      = busy;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_p     = rsp_p;
  assign bus.rsp_id    = rsp_id;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: directed and random transactions checked
// against a round-robin / signed-multiply reference model.
module tb_booth_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;
  localparam int AW   = NREQ * W;

  logic clk = 1'b0;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;
  int   ptr_m = 0;
  time  last_t = 0;
  int   got;

  booth_mul_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  booth_mul_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++)
      if (mask[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0]   sa, sb;
    logic signed [2*W-1:0] ea, eb, p;
    sa = a; sb = b;
    ea = sa; eb = sb;
    p  = ea * eb;
    return p;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic rand_ops();
    bus.req_a = AW'($urandom);
    bus.req_b = AW'($urandom);
  endtask

  // One full transaction from IDLE: grant, W calc edges, optional backpressure,
  // transfer. Operands are scrambled right after the accept edge.
  task automatic serve(input int delay, input bit chk_gap, output int w);
    logic [W-1:0]   a, b;
    logic [2*W-1:0] p;
    int             lat;
    #1;
    w = model_pick(bus.req_valid);
    if (w < 0) begin
      chk("no_request_to_serve", 32'd0, 32'd1);
      w = 0;
      return;
    end
    chk("req_ready_grant", 32'(bus.req_ready), 32'(1 << w));
    a = bus.req_a[w*W +: W];
    b = bus.req_b[w*W +: W];
    p = model_mul(a, b);
    bus.rsp_ready = (delay == 0);
    @(posedge clk);
    if (chk_gap) chk("accept_gap", 32'(($time - last_t) / 10), 32'(W + 2));
    last_t = $time;
    ptr_m = (w + 1) % NREQ;
    #1;
    rand_ops();
    chk("busy_calc", 32'(bus.busy), 32'd1);
    chk("req_ready_calc", 32'(bus.req_ready), 32'd0);
    lat = 0;
    while (!bus.rsp_valid && lat < 3 * W) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'(W));
    chk("rsp_p", 32'(bus.rsp_p), 32'(p));
    chk("rsp_id", 32'(bus.rsp_id), 32'(w));
    chk("busy_resp", 32'(bus.busy), 32'd1);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_p", 32'(bus.rsp_p), 32'(p));
      chk("hold_id", 32'(bus.rsp_id), 32'(w));
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("rsp_p_retained", 32'(bus.rsp_p), 32'(p));
    chk("rsp_id_retained", 32'(bus.rsp_id), 32'(w));
  endtask

  initial begin
    int exp_all[4]  = '{0, 1, 2, 3};
    int exp_02[2]   = '{0, 2};
    int exp_13[2]   = '{3, 1};
    logic [W-1:0] ca[5] = '{4'h8, 4'h8, 4'h0, 4'h5, 4'h7};
    logic [W-1:0] cb[5] = '{4'h8, 4'h7, 4'hB, 4'h5, 4'hF};
    logic [7:0]   cp[5] = '{8'h40, 8'hC8, 8'h00, 8'h19, 8'hF9};

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    #3;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_p", 32'(bus.rsp_p), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic 3 x -2 on requester 0.
    bus.req_valid = 4'b0001;
    set_op(0, 4'd3, 4'hE);
    serve(0, 1'b0, got);
    chk("basic_product_const", 32'(dut.rsp_p), 32'h00FA);

    for (int i = 0; i < 5; i++) begin
      set_op(0, ca[i], cb[i]);
      serve(0, 1'b0, got);
      chk("corner_const", 32'(bus.rsp_p), 32'(cp[i]));
    end

    // Reset between edges in the middle of CALC aborts the operation.
    bus.req_valid = 4'b1010;
    rand_ops();
    #1;
    @(posedge clk); #1;
    chk("busy_before_abort", 32'(bus.busy), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_rsp_p", 32'(bus.rsp_p), 32'd0);
    chk("abort_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
    #2;
    ptr_m = 0;
    bus.req_valid = 4'b1111;
    rand_ops();
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      serve(0, i > 0, got);
      chk("order_all", 32'(got), 32'(exp_all[i]));
    end
    bus.req_valid = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      serve(0, i > 0, got);
      chk("order_02", 32'(got), 32'(exp_02[i]));
    end
    bus.req_valid = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      serve(0, i > 0, got);
      chk("order_13", 32'(got), 32'(exp_13[i]));
    end

    // Backpressure with all requesters waiting; next accept one cycle after transfer.
    bus.req_valid = 4'b1111;
    serve(6, 1'b0, got);
    serve(0, 1'b0, got);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req_valid = '0;
        for (int i = 0; i < 2; i++) begin
          @(posedge clk); #1;
          chk("idle_req_ready", 32'(bus.req_ready), 32'd0);
          chk("idle_busy", 32'(bus.busy), 32'd0);
        end
      end
      bus.req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rand_ops();
      serve(int'($urandom_range(0, 3)), 1'b0, got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
